uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side buffer directly downstream of the UART receiver. Captures each {error,data[7:0]} word on the
//  receiver's load strobe, queues it in a FIFO, and exposes it to the Nios II over an Avalon-MM slave
//  (data pop, status, control, frame-error counter) with a level interrupt. Decouples byte arrival from CPU polling.
// PARAMETERS
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 words (9 bits each); 1..8 legal
// PORTS
//  clk            in   1   system clock; must be >= the receiver's oversample clock
//  reset_n        in   1   asynchronous, active-low reset
//  rx_load        in   1   receiver word-done strobe; may be async to clk, high >= 1 receiver clock
//  rx_word        in   9   {frame_error, data[7:0]}; stable >= 3 clk after rx_load rises
//  avs_address    in   2   0=DATA 1=STATUS 2=CONTROL 3=ERRCNT
//  avs_read       in   1   Avalon read strobe
//  avs_write      in   1   Avalon write strobe
//  avs_writedata  in   32  write data
//  avs_readdata   out  32  read data, registered, fixed read latency 1
//  irq            out  1   level interrupt, registered
// BEHAVIOUR
//  Reset: FIFO empty (wr_ptr=rd_ptr=count=0), overrun=0, irq_en=0, errcnt=0, avs_readdata=0, irq=0, sync flops=0.
//  Capture: rx_load -> 2-flop synchroniser -> rising-edge detect on 2nd/3rd flop; push=edge (one clk).
//   rx_word sampled on the push cycle (no sync; stability guaranteed by receiver). Push-to-EMPTY=0 latency 3 clk.
//  Push: if !full or pop same cycle -> mem[wr_ptr]<=rx_word, wr_ptr++ (wraps mod depth).
//   If full and no pop -> word dropped, overrun<=1 (sticky). If rx_word[8]=1 on any push event -> errcnt++,
//   saturating at 255 (counted even if dropped).
//  Pop: avs_read & address 0. If !empty: readdata<={1'b1,22'b0,mem[rd_ptr]}, rd_ptr++ (wraps).
//   If empty: readdata<=0 (bit31 valid=0), no pointer change.
//  count: DEPTH_LOG2+1 bits; push&pop -> unchanged; push only ->+1; pop only ->-1. full=(count==depth), empty=(count==0).
//  Simultaneous push+pop when empty: pop returns valid=0, push stored (count 0->1).
//  Simultaneous push+pop when full: both succeed, count stays depth, no overrun.
//  STATUS read (addr1): {16'b0, count[7:0] zero-extended in [15:8], 4'b0, overrun[3], full[2], empty[1], irq_en[0]}.
//  STATUS write: writedata[3]=1 clears overrun (W1C); other bits ignored. Set by a same-cycle drop wins over clear.
//  CONTROL read (addr2): {31'b0, irq_en}. Write: irq_en<=wd[0]; wd[1]=1 -> flush: pointers/count<=0, overrun<=0;
//   a push in the flush cycle is discarded (no overrun). errcnt unaffected by flush.
//  ERRCNT (addr3): read {24'b0,errcnt}; any write clears to 0 (same-cycle increment is lost).
//  Reads of non-DATA addresses have no side effects. avs_read and avs_write together: write takes effect,
//   readdata still returns pre-write value of addressed register.
//  irq <= irq_en & (!empty | overrun), evaluated from next-state values; deasserts the cycle after last pop/clear.
//  reset_n asserted mid-word: all state cleared immediately; a pending sync'd edge is lost (not pushed).
// TESTING
//  1 Reset then read STATUS -> 0x00000002 (empty=1); read DATA -> 0x00000000; irq=0.
//  2 Three rx_load pulses with 0x041,0x042,0x143 -> STATUS count=3; DATA reads 0x80000041,0x80000042,
//    0x80000143; ERRCNT=1; 4th DATA read -> 0x00000000.
//  3 DEPTH_LOG2=4: push 17 words 0x00..0x10 -> full=1, overrun=1, pops return 0x00..0x0F in order (0x10 lost);
//    write STATUS 0x8 -> overrun=0.
//  4 Push coincident with DATA pop at count=16 -> no overrun, count stays 16; at count=0 -> readdata valid=0, count=1.
//  5 CONTROL=0x1 then push 0x055 -> irq=1 within 4 clk of rx_load; pop -> irq=0 next cycle; CONTROL=0x3 with 5
//    queued -> count=0, empty=1, irq=0.
//  6 rx_load held high 20 clk (slow receiver clock) -> exactly one push; reset_n pulsed low mid-sequence -> count=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and the Nios II: synchronises the load strobe,
// queues {error,data} words and exposes them over an Avalon-MM slave with a level interrupt.
module uart_rx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_load,
    input  logic [8:0]  rx_word,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_ERRCNT = 2'd3;

    logic [2:0]       sync_q,     sync_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             overrun_q,  overrun_d;
    logic             irq_en_q,   irq_en_d;
    logic [7:0]       errcnt_q,   errcnt_d;
    logic [31:0]      rdata_q,    rdata_d;
    logic             irq_q,      irq_d;
    logic [8:0]       mem_q [DEPTH];

    logic push_c, pop_c, push_ok_c, drop_c, flush_c, empty_c, full_c;
    logic unused_wdata;

    assign unused_wdata = ^{avs_writedata[31:4], avs_writedata[2]};

    // Datapath next-state: capture, FIFO pointers, registers and read mux.
    always_comb begin
        sync_d    = {sync_q[1:0], rx_load};
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        irq_en_d  = irq_en_q;
        errcnt_d  = errcnt_q;
        rdata_d   = rdata_q;

        empty_c   = (count_q == CNT_W'(0));
        full_c    = (count_q == CNT_W'(DEPTH));
        push_c    = sync_q[1] & ~sync_q[2];
        flush_c   = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[1];
        pop_c     = avs_read && (avs_address == ADDR_DATA) && !empty_c;
        push_ok_c = push_c && (!full_c || pop_c) && !flush_c;
        drop_c    = push_c && full_c && !pop_c && !flush_c;

        if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok_c && !pop_c)      count_d = count_q + CNT_W'(1);
        else if (pop_c && !push_ok_c) count_d = count_q - CNT_W'(1);

        // A drop in the same cycle as a W1C clear keeps overrun set.
        if (avs_write && (avs_address == ADDR_STATUS) && avs_writedata[3]) overrun_d = 1'b0;
        if (drop_c) overrun_d = 1'b1;

        if (avs_write && (avs_address == ADDR_CTRL)) irq_en_d = avs_writedata[0];

        if (push_c && rx_word[8] && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
        if (avs_write && (avs_address == ADDR_ERRCNT))   errcnt_d = 8'd0;

        if (flush_c) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end

        if (avs_read) begin
            unique case (avs_address)
                ADDR_DATA:   rdata_d = pop_c ? {1'b1, 22'b0, mem_q[rd_ptr_q]} : 32'd0;
                ADDR_STATUS: rdata_d = {16'b0, 8'(count_q), 4'b0, overrun_q, full_c, empty_c, irq_en_q};
                ADDR_CTRL:   rdata_d = {31'b0, irq_en_q};
                ADDR_ERRCNT: rdata_d = {24'b0, errcnt_q};
                default:     rdata_d = 32'd0;
            endcase
        end

        irq_d = irq_en_d & ((count_d != CNT_W'(0)) | overrun_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_en_q  <= 1'b0;
            errcnt_q  <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_en_q  <= irq_en_d;
            errcnt_q  <= errcnt_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    // Storage array is not reset; only words behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= rx_word;
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule
